// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronises the slot sensor and done button, debounces insertions,
// maps sizes to coins/credit, and runs the session. `COIN_TIMEOUT_EN adds an idle auto-finish timer.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int MAX_CREDIT      = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        coin_sense,
  input  logic [1:0]  coin_size,
  input  logic        done_btn,
  input  logic        session_clr,
  output logic [1:0]  coin,
  output logic        drop_coin,
  output logic        finish_coin,
  output logic [10:0] credit,
  output logic        reject
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, ACCEPT, HOLD, FINISHED} state_t;

  state_t           state_reg, state_next;
  logic             sense_meta_reg, sense_sync_reg;
  logic             btn_meta_reg, btn_sync_reg, btn_prev_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       size_reg, size_next;
  logic [1:0]       coin_reg, coin_next;
  logic [1:0]       drop_cnt_reg, drop_cnt_next;
  logic             finish_reg, finish_next;
  logic [10:0]      credit_reg, credit_next;
  logic             reject_reg, reject_next;
  logic             done_pend_reg, done_pend_next;
  logic             btn_rise, done_req, timeout_hit;
  logic [1:0]       code;
  logic [11:0]      value, sum;

`ifdef COIN_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_reg, timer_next;
`endif

  assign btn_rise = btn_sync_reg & ~btn_prev_reg;
  // A press seen while debouncing/accepting is held until IDLE or HOLD can act on it.
  assign done_req = btn_rise | done_pend_reg;

  always_comb begin
    code  = 2'd0;
    value = 12'd10;
    case (size_reg)
      2'd0: begin code = 2'd0; value = 12'd10;  end
      2'd1: begin code = 2'd1; value = 12'd20;  end
      2'd2: begin code = 2'd3; value = 12'd50;  end
      2'd3: begin code = 2'd2; value = 12'd100; end
      default: ;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    size_next      = size_reg;
    coin_next      = coin_reg;
    drop_cnt_next  = (drop_cnt_reg != 2'd0) ? drop_cnt_reg - 2'd1 : 2'd0;
    finish_next    = finish_reg;
    credit_next    = credit_reg;
    reject_next    = 1'b0;
    done_pend_next = done_pend_reg | btn_rise;
    timeout_hit    = 1'b0;
    sum            = {1'b0, credit_reg} + value;
`ifdef COIN_TIMEOUT_EN
    timer_next = timer_reg;
    if ((state_reg == IDLE || state_reg == HOLD) && credit_reg != '0 && timer_reg != '0) begin
      timer_next  = timer_reg - TMR_W'(1);
      timeout_hit = (timer_reg == TMR_W'(1));
    end
`endif

    case (state_reg)
      IDLE: begin
        if (done_req || timeout_hit) begin
          state_next = FINISHED;
        end else if (sense_sync_reg) begin
          state_next = DEBOUNCE;
          cnt_next   = CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES)) begin
          size_next  = coin_size;
          state_next = ACCEPT;
        end else if (!sense_sync_reg) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ACCEPT: begin
        state_next = HOLD;
        // 12-bit sum keeps the ceiling compare exact even near the 11-bit limit.
        if (sum <= 12'(MAX_CREDIT)) begin
          credit_next   = sum[10:0];
          coin_next     = code;
          drop_cnt_next = 2'd2;
`ifdef COIN_TIMEOUT_EN
          timer_next = TMR_W'(TIMEOUT_CYCLES);
`endif
        end else begin
          reject_next = 1'b1;
        end
      end
      HOLD: begin
        if (done_req || timeout_hit) begin
          state_next = FINISHED;
        end else if (!sense_sync_reg) begin
          state_next = IDLE;
        end
      end
      FINISHED: begin
        if (session_clr) begin
          state_next  = IDLE;
          finish_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next == FINISHED && state_reg != FINISHED) begin
      finish_next = 1'b1;
    end
    if (state_next == FINISHED || state_reg == FINISHED) begin
      done_pend_next = 1'b0;
    end

    // Clear wins over a same-cycle accept; FSM state and in-flight drop pulse are untouched.
    if (session_clr) begin
      credit_next = '0;
`ifdef COIN_TIMEOUT_EN
      timer_next = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      sense_meta_reg <= 1'b0;
      sense_sync_reg <= 1'b0;
      btn_meta_reg   <= 1'b0;
      btn_sync_reg   <= 1'b0;
      btn_prev_reg   <= 1'b0;
      cnt_reg        <= '0;
      size_reg       <= 2'd0;
      coin_reg       <= 2'd0;
      drop_cnt_reg   <= 2'd0;
      finish_reg     <= 1'b0;
      credit_reg     <= '0;
      reject_reg     <= 1'b0;
      done_pend_reg  <= 1'b0;
`ifdef COIN_TIMEOUT_EN
      timer_reg      <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      sense_meta_reg <= coin_sense;
      sense_sync_reg <= sense_meta_reg;
      btn_meta_reg   <= done_btn;
      btn_sync_reg   <= btn_meta_reg;
      btn_prev_reg   <= btn_sync_reg;
      cnt_reg        <= cnt_next;
      size_reg       <= size_next;
      coin_reg       <= coin_next;
      drop_cnt_reg   <= drop_cnt_next;
      finish_reg     <= finish_next;
      credit_reg     <= credit_next;
      reject_reg     <= reject_next;
      done_pend_reg  <= done_pend_next;
`ifdef COIN_TIMEOUT_EN
      timer_reg      <= timer_next;
`endif
    end
  end

  assign coin        = coin_reg;
  assign drop_coin   = (drop_cnt_reg != 2'd0);
  assign finish_coin = finish_reg;
  assign credit      = credit_reg;
  assign reject      = reject_reg;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: a negedge monitor pops scoreboard entries
// on each drop_coin/reject event; scenario tasks check levels inline.
module tb_coin_acceptor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        coin_sense = 1'b0;
  logic [1:0]  coin_size = 2'd0;
  logic        done_btn = 1'b0;
  logic        session_clr = 1'b0;
  logic [1:0]  coin;
  logic        drop_coin, finish_coin, reject;
  logic [10:0] credit;

  typedef struct packed {
    logic        is_reject;
    logic [1:0]  code;
    logic [10:0] credit;
  } exp_t;

  exp_t   exp_q[$];
  int     tests_run = 0;
  int     tests_failed = 0;
  int     model_credit = 0;
  int     drop_events = 0;
  int     reject_events = 0;
  longint cycle = 0;
  longint last_drop_cycle = 0;
  logic   drop_prev = 1'b0;
  logic   reject_prev = 1'b0;
  int     drop_len = 0;
  logic [1:0] drop_code = 2'd0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (50),
    .MAX_CREDIT     (2000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_sense (coin_sense),
    .coin_size  (coin_size),
    .done_btn   (done_btn),
    .session_clr(session_clr),
    .coin       (coin),
    .drop_coin  (drop_coin),
    .finish_coin(finish_coin),
    .credit     (credit),
    .reject     (reject)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Event monitor: every drop/reject must match the oldest scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      drop_prev   = 1'b0;
      reject_prev = 1'b0;
      drop_len    = 0;
    end else begin
      if (drop_coin && !drop_prev) begin
        drop_events++;
        last_drop_cycle = cycle;
        drop_len  = 1;
        drop_code = coin;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_drop: got coin=%0d credit=%0d, required no event", coin, credit);
        end else begin
          e = exp_q.pop_front();
          if (e.is_reject !== 1'b0 || coin !== e.code || credit !== e.credit) begin
            tests_failed++;
            $display("FAIL drop_event: got drop coin=%0d credit=%0d, required reject=%0b coin=%0d credit=%0d",
                     coin, credit, e.is_reject, e.code, e.credit);
          end
        end
      end else if (drop_coin && drop_prev) begin
        drop_len++;
        tests_run++;
        if (coin !== drop_code) begin
          tests_failed++;
          $display("FAIL coin_stable: got coin=%0d, required %0d", coin, drop_code);
        end
      end else if (!drop_coin && drop_prev) begin
        tests_run++;
        if (drop_len !== 2) begin
          tests_failed++;
          $display("FAIL drop_width: got %0d cycles, required 2", drop_len);
        end
      end
      if (reject && !reject_prev) begin
        reject_events++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_reject: got reject credit=%0d, required no event", credit);
        end else begin
          e = exp_q.pop_front();
          if (e.is_reject !== 1'b1 || credit !== e.credit) begin
            tests_failed++;
            $display("FAIL reject_event: got reject credit=%0d, required reject=%0b credit=%0d",
                     credit, e.is_reject, e.credit);
          end
        end
      end else if (reject && reject_prev) begin
        tests_run++;
        tests_failed++;
        $display("FAIL reject_width: got reject high 2+ cycles, required 1");
      end
      drop_prev   = drop_coin;
      reject_prev = reject;
    end
  end

  task automatic insert_coin(input logic [1:0] size, input int hold, input bit expect_evt);
    int   value;
    exp_t e;
    value = (size == 2'd0) ? 10 : (size == 2'd1) ? 20 : (size == 2'd2) ? 50 : 100;
    if (expect_evt) begin
      e.code = (size == 2'd0) ? 2'd0 : (size == 2'd1) ? 2'd1 : (size == 2'd2) ? 2'd3 : 2'd2;
      if (model_credit + value <= 2000) begin
        model_credit += value;
        e.is_reject = 1'b0;
      end else begin
        e.is_reject = 1'b1;
      end
      e.credit = 11'(model_credit);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    coin_size  = size;
    coin_sense = 1'b1;
    repeat (hold) @(posedge clk);
    #1 coin_sense = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("[TB] coin size=%0d hold=%0d -> credit=%0d", size, hold, credit);
  endtask

  task automatic clear_session();
    @(posedge clk); #1 session_clr = 1'b1;
    @(posedge clk); #1 session_clr = 1'b0;
    model_credit = 0;
  endtask

  task automatic press_done();
    @(posedge clk); #1 done_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 done_btn = 1'b0;
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: got %0d pending events, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({coin, drop_coin, finish_coin, reject, credit} !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got coin=%0d drop=%0b fin=%0b rej=%0b credit=%0d, required all 0",
               coin, drop_coin, finish_coin, reject, credit);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset released");
  endtask

  task automatic test_single_coin();
    int ev;
    clear_session();
    ev = drop_events;
    insert_coin(2'd2, 10, 1'b1);
    check_drained("single");
    tests_run++;
    if (credit !== 11'd50 || drop_events - ev !== 1) begin
      tests_failed++;
      $display("FAIL single_coin: got credit=%0d drops=%0d, required credit=50 drops=1", credit, drop_events - ev);
    end
  endtask

  task automatic test_glitch();
    int dev, rev;
    clear_session();
    dev = drop_events;
    rev = reject_events;
    insert_coin(2'd2, 3, 1'b0);
    tests_run++;
    if (credit !== 11'd0 || drop_events !== dev || reject_events !== rev) begin
      tests_failed++;
      $display("FAIL glitch: got credit=%0d drops=%0d rejects=%0d, required 0/0/0",
               credit, drop_events - dev, reject_events - rev);
    end
  endtask

  task automatic test_back_to_back();
    clear_session();
    for (int s = 0; s < 4; s++) insert_coin(2'(s), 4, 1'b1);
    check_drained("b2b");
    tests_run++;
    if (credit !== 11'd180) begin
      tests_failed++;
      $display("FAIL b2b_credit: got %0d, required 180", credit);
    end
  endtask

  task automatic test_max_credit();
    int rev;
    clear_session();
    for (int i = 0; i < 20; i++) insert_coin(2'd3, 5, 1'b1);
    tests_run++;
    if (credit !== 11'd2000) begin
      tests_failed++;
      $display("FAIL max_fill: got %0d, required 2000", credit);
    end
    rev = reject_events;
    insert_coin(2'd3, 5, 1'b1);
    check_drained("max");
    tests_run++;
    if (credit !== 11'd2000 || reject_events - rev !== 1) begin
      tests_failed++;
      $display("FAIL max_reject: got credit=%0d rejects=%0d, required 2000/1", credit, reject_events - rev);
    end
  endtask

  task automatic test_finish();
    int dev, rev;
    clear_session();
    insert_coin(2'd1, 5, 1'b1);
    press_done();
    for (int i = 0; i < 10 && finish_coin !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (finish_coin !== 1'b1) begin
      tests_failed++;
      $display("FAIL finish_rise: got finish_coin=%0b, required 1", finish_coin);
    end
    dev = drop_events;
    rev = reject_events;
    insert_coin(2'd2, 6, 1'b0);
    tests_run++;
    if (credit !== 11'd20 || finish_coin !== 1'b1 || drop_events !== dev || reject_events !== rev) begin
      tests_failed++;
      $display("FAIL finished_ignore: got credit=%0d fin=%0b drops=%0d rejects=%0d, required 20/1/0/0",
               credit, finish_coin, drop_events - dev, reject_events - rev);
    end
    clear_session();
    #1;
    tests_run++;
    if (credit !== 11'd0 || finish_coin !== 1'b0) begin
      tests_failed++;
      $display("FAIL session_clr: got credit=%0d fin=%0b, required 0/0", credit, finish_coin);
    end
    check_drained("finish");
  endtask

  task automatic test_done_zero_credit();
    clear_session();
    press_done();
    for (int i = 0; i < 10 && finish_coin !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (finish_coin !== 1'b1 || credit !== 11'd0) begin
      tests_failed++;
      $display("FAIL done_zero: got fin=%0b credit=%0d, required 1/0", finish_coin, credit);
    end
    clear_session();
    $display("[TB] done with zero credit -> finish observed, cleared");
  endtask

  task automatic test_accept_clr();
    exp_t e;
    clear_session();
    e.is_reject = 1'b0;
    e.code      = 2'd0;
    e.credit    = 11'd0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    coin_size  = 2'd0;
    coin_sense = 1'b1;
    repeat (6) @(posedge clk);
    #1 session_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 session_clr = 1'b0;
    coin_sense = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_drained("accept_clr");
    tests_run++;
    if (credit !== 11'd0) begin
      tests_failed++;
      $display("FAIL accept_clr: got credit=%0d, required 0", credit);
    end
    $display("[TB] accept with concurrent clear -> credit=%0d", credit);
  endtask

  task automatic test_timeout();
    longint fin_cycle;
    clear_session();
    insert_coin(2'd0, 5, 1'b1);
    check_drained("timeout");
`ifdef COIN_TIMEOUT_EN
    fin_cycle = -1;
    for (int i = 0; i < 80; i++) begin
      if (finish_coin === 1'b1) begin
        fin_cycle = cycle;
        break;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (fin_cycle < 0 || fin_cycle - last_drop_cycle < 49 || fin_cycle - last_drop_cycle > 51) begin
      tests_failed++;
      $display("FAIL timeout: got finish after %0d cycles, required 50 +/-1",
               (fin_cycle < 0) ? -1 : fin_cycle - last_drop_cycle);
    end
`else
    fin_cycle = 0;
    for (int i = 0; i < 80; i++) begin
      if (finish_coin === 1'b1) fin_cycle = cycle;
      @(posedge clk); #1;
    end
    tests_run++;
    if (fin_cycle != 0) begin
      tests_failed++;
      $display("FAIL no_timeout: got finish_coin=1, required 0");
    end
`endif
    clear_session();
    $display("[TB] timeout scenario done, finish_coin=%0b", finish_coin);
  endtask

  task automatic test_reset_mid_pulse();
    int dev;
    clear_session();
    @(posedge clk); #1;
    coin_size  = 2'd3;
    coin_sense = 1'b1;
    for (int i = 0; i < 30 && drop_coin !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (drop_coin !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pulse_wait: got drop_coin=%0b, required 1", drop_coin);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({coin, drop_coin, finish_coin, reject, credit} !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got coin=%0d drop=%0b fin=%0b rej=%0b credit=%0d, required all 0",
               coin, drop_coin, finish_coin, reject, credit);
    end
    coin_sense = 1'b0;
    dev = drop_events;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_credit = 0;
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (credit !== 11'd0 || drop_events !== dev) begin
      tests_failed++;
      $display("FAIL reset_release: got credit=%0d drops=%0d, required 0/0", credit, drop_events - dev);
    end
    $display("[TB] reset during drop -> credit=%0d after release", credit);
  endtask

  initial begin
    test_reset();
    test_single_coin();
    test_glitch();
    test_back_to_back();
    test_max_credit();
    test_finish();
    test_done_zero_credit();
    test_accept_clr();
    test_timeout();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive stable-high sample cycles needed to accept a coin.
REQ-002 Parameter: TIMEOUT_CYCLES, default 1000, idle cycles after the last accepted coin before auto-finish.
REQ-003 Parameter: MAX_CREDIT, default 2000, credit ceiling in money units.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 coin_sense  input  1  raw, asynchronous slot sensor; high while a coin is in the slot.
REQ-007 coin_size  input  2  sensor size class; valid while coin_sense is high.
REQ-008 done_btn  input  1  raw, asynchronous "finished inserting" button.
REQ-009 session_clr  input  1  synchronous one-cycle pulse from the vendor controller; ends the session.
REQ-010 coin  output  2  denomination code of the last accepted coin: 0=10, 1=20, 3=50, 2=100.
REQ-011 drop_coin  output  1  high for exactly 2 cycles per accepted coin; coin is stable throughout.
REQ-012 finish_coin  output  1  level; high from session finish until session_clr.
REQ-013 credit  output  11  running sum of accepted coin values, unsigned.
REQ-014 reject  output  1  one-cycle pulse when a debounced coin is refused.

Function
REQ-015 coin_sense and done_btn SHALL each pass through a 2-flop synchronizer before use; sync latency is 2 cycles.
REQ-016 Coin FSM states: IDLE, DEBOUNCE, ACCEPT, HOLD, FINISHED.
REQ-017 IDLE -> DEBOUNCE when synced sense is high; the debounce counter loads 1.
REQ-018 DEBOUNCE: each high cycle increments the counter; any low cycle returns to IDLE with no output.
REQ-019 At count == DEBOUNCE_CYCLES: sample coin_size and go to ACCEPT.
REQ-020 ACCEPT (1 cycle): if credit + value <= MAX_CREDIT, then update credit, drive coin, and start the 2-cycle drop_coin pulse; otherwise pulse reject and leave credit unchanged.
REQ-021 ACCEPT then moves to HOLD; HOLD waits for synced sense low before returning to IDLE, so one insertion is counted once.
REQ-022 Value mapping: coin_size 0 -> code 0, value 10; 1 -> code 1, value 20; 2 -> code 3, value 50; 3 -> code 2, value 100.
REQ-023 Credit arithmetic SHALL use a 12-bit compare, so an 11-bit sum never wraps.
REQ-024 Rising edge of synced done_btn in IDLE or HOLD -> FINISHED; finish_coin rises the next cycle.
REQ-025 done_btn is ignored during DEBOUNCE/ACCEPT until the FSM reaches HOLD or IDLE; an edge seen then is serviced on arrival.
REQ-026 done_btn with credit == 0 SHALL still finish the session.
REQ-027 FINISHED: coin_sense is ignored (no drop_coin, no reject); finish_coin stays high.
REQ-028 session_clr in FINISHED: credit <- 0, finish_coin <- 0, next state IDLE.
REQ-029 session_clr in any other state: credit <- 0 and the timeout timer is cleared; the FSM state and any drop_coin pulse already in flight are kept.
REQ-030 If ACCEPT and session_clr fall in the same cycle, the clear wins and credit ends at 0.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE; credit 0; coin 0; drop_coin 0; finish_coin 0; reject 0; all counters and synchronizers 0.
REQ-032 Reset mid-pulse or mid-debounce aborts the operation; no output is reissued after release.

Configuration
REQ-033 Macro COIN_TIMEOUT_EN defined: the timer reloads on every accepted coin and decrements in IDLE/HOLD while credit > 0.
REQ-034 With COIN_TIMEOUT_EN, reaching 0 forces FINISHED exactly as done_btn does; a reject does not reload the timer.
REQ-035 Macro undefined: no timer logic; FINISHED is reached only via done_btn.

Verification
REQ-036 Stimulus: coin_sense high 10 cycles, size 2 -> one drop_coin of 2 cycles, coin=3, credit=50.
REQ-037 Stimulus: coin_sense glitch of 3 cycles, DEBOUNCE_CYCLES=4 -> no drop_coin, no reject, credit=0.
REQ-038 Stimulus: 20 coins of size 3, MAX_CREDIT=2000 -> credit=2000; a 21st coin -> reject pulse, credit stays 2000.
REQ-039 Stimulus: insert 20, then done_btn -> finish_coin=1; a further coin is ignored; session_clr -> credit=0, finish_coin=0.
REQ-040 Stimulus (COIN_TIMEOUT_EN, TIMEOUT_CYCLES=50): one coin, then idle -> finish_coin rises 50 cycles +/-1 after drop_coin; without the macro it never rises.
REQ-041 Stimulus: rst_n low during drop_coin -> all outputs 0 immediately; credit=0 after release.
